// File: rtl/paillier_pkg.sv
// Shared types for the Paillier batch key generator:
// controller and inverter state encodings, record field slices.
package paillier_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      COMPUTE,
      INV_REQ,
      INV_WAIT,
      WRITE,
      FINISH
   } state_e;

   typedef enum logic [1:0] {
      MI_IDLE,
      MI_REDUCE,
      MI_RUN,
      MI_DONE
   } inv_state_e;

   // Record layout: {p, q}, q in the low half.
   localparam int unsigned REC_Q_LSB = 0;

   function automatic int unsigned rec_q_msb(input int unsigned dw);
      return dw / 2 - 1;
   endfunction

   function automatic int unsigned rec_p_lsb(input int unsigned dw);
      return dw / 2;
   endfunction

   function automatic int unsigned rec_p_msb(input int unsigned dw);
      return dw - 1;
   endfunction

endpackage

// File: rtl/mod_inverse.sv
// Sequential modular inverse (binary extended Euclid), odd modulus.
// One reduction / halving / subtraction step per clock.
module mod_inverse
   import paillier_pkg::*;
#(
   parameter int DATA_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  din_valid,
   output logic                  din_ready,
   input  logic [DATA_WIDTH-1:0] din_base,
   input  logic [DATA_WIDTH-1:0] din_mod,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DATA_WIDTH-1:0] dout_res,
   output logic                  dout_err
);

   localparam int W = DATA_WIDTH;
   localparam logic [W-1:0] W_ONE   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] W_THREE = {{(W-2){1'b0}}, 2'b11};

   inv_state_e   st_q;
   logic [W-1:0] u_q, v_q, x1_q, x2_q, m_q, res_q;
   logic         err_q;
   logic [W-1:0] h1_d, h2_d, s12_d, s21_d;

   // x/2 mod m for odd m: add m first when x is odd
   function automatic logic [W-1:0] halve(input logic [W-1:0] x,
                                          input logic [W-1:0] m);
      logic [W:0] t;
      t = {1'b0, x} + (x[0] ? {1'b0, m} : {(W+1){1'b0}});
      return t[W:1];
   endfunction

   // (a - b) mod m for a, b < m; wraparound lands back in [0, m)
   function automatic logic [W-1:0] msub(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] m);
      return (a >= b) ? (a - b) : (a - b + m);
   endfunction

   assign din_ready  = (st_q == MI_IDLE);
   assign dout_valid = (st_q == MI_DONE);
   assign dout_res   = res_q;
   assign dout_err   = err_q;

   // candidate coefficient updates for the current step
   always_comb begin
      h1_d  = halve(x1_q, m_q);
      h2_d  = halve(x2_q, m_q);
      s12_d = msub(x1_q, x2_q, m_q);
      s21_d = msub(x2_q, x1_q, m_q);
   end

   // inversion engine: invariants x1*a == u, x2*a == v (mod m)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q  <= MI_IDLE;
         u_q   <= '0;
         v_q   <= '0;
         x1_q  <= '0;
         x2_q  <= '0;
         m_q   <= '0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         unique case (st_q)
            MI_IDLE: begin
               if (din_valid) begin
                  m_q   <= din_mod;
                  u_q   <= din_base;
                  v_q   <= din_mod;
                  x1_q  <= W_ONE;
                  x2_q  <= '0;
                  res_q <= '0;
                  err_q <= 1'b0;
                  if (din_mod < W_THREE || !din_mod[0]) begin
                     err_q <= 1'b1;
                     st_q  <= MI_DONE;
                  end else begin
                     st_q  <= MI_REDUCE;
                  end
               end
            end
            MI_REDUCE: begin
               if (u_q >= m_q) u_q <= u_q - m_q;
               else            st_q <= MI_RUN;
            end
            MI_RUN: begin
               if (u_q == '0 || v_q == '0) begin
                  err_q <= 1'b1;
                  st_q  <= MI_DONE;
               end else if (u_q == W_ONE) begin
                  res_q <= x1_q;
                  st_q  <= MI_DONE;
               end else if (v_q == W_ONE) begin
                  res_q <= x2_q;
                  st_q  <= MI_DONE;
               end else if (!u_q[0]) begin
                  u_q  <= u_q >> 1;
                  x1_q <= h1_d;
               end else if (!v_q[0]) begin
                  v_q  <= v_q >> 1;
                  x2_q <= h2_d;
               end else if (u_q >= v_q) begin
                  u_q  <= u_q - v_q;
                  x1_q <= s12_d;
               end else begin
                  v_q  <= v_q - u_q;
                  x2_q <= s21_d;
               end
            end
            MI_DONE: begin
               if (dout_ready) st_q <= MI_IDLE;
            end
            default: st_q <= MI_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/paillier_keygen_batch.sv
// Batch Paillier key generator: reads (p,q) records, writes
// {mu, lambda, g, n} records with a per-record valid flag.
module paillier_keygen_batch
   import paillier_pkg::*;
#(
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 64,
   parameter int RD_LATENCY    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [ADDRESS_WIDTH-1:0]   num_keys,
   input  logic [ADDRESS_WIDTH-1:0]   rd_base,
   input  logic [ADDRESS_WIDTH-1:0]   wr_base,
   output logic                       mem_rd_en,
   output logic [ADDRESS_WIDTH-1:0]   mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]      mem_rd_data,
   output logic                       mem_wr_en,
   output logic [ADDRESS_WIDTH-1:0]   mem_wr_addr,
   output logic [4*DATA_WIDTH-1:0]    mem_wr_data,
   output logic                       mem_wr_ok,
   output logic                       busy,
   output logic                       done,
   output logic [ADDRESS_WIDTH-1:0]   err_count
);

   localparam int DW = DATA_WIDTH;
   localparam int HW = DATA_WIDTH / 2;
   localparam int AW = ADDRESS_WIDTH;
   localparam int unsigned P_MSB = rec_p_msb(DATA_WIDTH);
   localparam int unsigned P_LSB = rec_p_lsb(DATA_WIDTH);
   localparam int unsigned Q_MSB = rec_q_msb(DATA_WIDTH);
   localparam logic [DW-1:0] DW_ONE   = {{(DW-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0] AW_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [HW-1:0] HW_THREE = {{(HW-2){1'b0}}, 2'b11};
   localparam logic [2:0]    LAT_LAST = 3'(RD_LATENCY - 1);

   state_e          state_q;
   logic [AW-1:0]   idx_q, num_q, rdb_q, wrb_q;
   logic [2:0]      lat_q;
   logic [HW-1:0]   p_q, q_q;
   logic [DW-1:0]   n_q, lam_q, g_q;
   logic            rd_en_q, wr_en_q, wr_ok_q, busy_q, done_q;
   logic [AW-1:0]   rd_addr_q, wr_addr_q, err_q;
   logic [4*DW-1:0] wr_data_q;

   logic [DW-1:0]   pw_d, qw_d, n_d, lam_d, g_d;
   logic            bad_d;
   logic [AW-1:0]   idx_d, err_d;

   logic            inv_din_valid, inv_din_ready;
   logic            inv_dout_valid, inv_dout_ready, inv_dout_err;
   logic [DW-1:0]   inv_dout_res;

   assign mem_rd_en   = rd_en_q;
   assign mem_rd_addr = rd_addr_q;
   assign mem_wr_en   = wr_en_q;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign mem_wr_ok   = wr_ok_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err_count   = err_q;

   assign inv_din_valid  = (state_q == INV_REQ);
   assign inv_dout_ready = (state_q == INV_WAIT);

   mod_inverse #(
      .DATA_WIDTH(DW)
   ) u_inv (
      .clk        (clk),
      .rst_n      (rst_n),
      .din_valid  (inv_din_valid),
      .din_ready  (inv_din_ready),
      .din_base   (lam_q),
      .din_mod    (n_q),
      .dout_valid (inv_dout_valid),
      .dout_ready (inv_dout_ready),
      .dout_res   (inv_dout_res),
      .dout_err   (inv_dout_err)
   );

   // key arithmetic on the captured record, full DATA_WIDTH wrap
   always_comb begin
      pw_d  = DW'(p_q);
      qw_d  = DW'(q_q);
      n_d   = pw_d * qw_d;
      lam_d = (pw_d - DW_ONE) * (qw_d - DW_ONE);
      g_d   = n_d + DW_ONE;
      bad_d = (p_q < HW_THREE) || (q_q < HW_THREE) ||
              (p_q == q_q) || !p_q[0] || !q_q[0];
      idx_d = idx_q + AW_ONE;
      err_d = (err_q == '1) ? err_q : err_q + AW_ONE;
   end

   // batch controller with registered memory and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         num_q     <= '0;
         rdb_q     <= '0;
         wrb_q     <= '0;
         lat_q     <= '0;
         p_q       <= '0;
         q_q       <= '0;
         n_q       <= '0;
         lam_q     <= '0;
         g_q       <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_ok_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  idx_q  <= '0;
                  num_q  <= num_keys;
                  rdb_q  <= rd_base;
                  wrb_q  <= wr_base;
                  err_q  <= '0;
                  busy_q <= 1'b1;
                  if (num_keys == '0) begin
                     state_q <= FINISH;
                  end else begin
                     state_q   <= FETCH;
                     rd_en_q   <= 1'b1;
                     rd_addr_q <= rd_base;
                  end
               end
            end
            FETCH: begin
               rd_en_q <= 1'b0;
               lat_q   <= '0;
               state_q <= WAIT_RD;
            end
            WAIT_RD: begin
               if (lat_q == LAT_LAST) begin
                  p_q     <= mem_rd_data[P_MSB:P_LSB];
                  q_q     <= mem_rd_data[Q_MSB:REC_Q_LSB];
                  state_q <= COMPUTE;
               end else begin
                  lat_q <= lat_q + 3'd1;
               end
            end
            COMPUTE: begin
               n_q   <= n_d;
               lam_q <= lam_d;
               g_q   <= g_d;
               if (bad_d) begin
                  err_q     <= err_d;
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= wrb_q + idx_q;
                  wr_data_q <= {{DW{1'b0}}, lam_d, g_d, n_d};
                  wr_ok_q   <= 1'b0;
                  state_q   <= WRITE;
               end else begin
                  state_q <= INV_REQ;
               end
            end
            INV_REQ: begin
               if (inv_din_ready) state_q <= INV_WAIT;
            end
            INV_WAIT: begin
               if (inv_dout_valid) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= wrb_q + idx_q;
                  state_q   <= WRITE;
                  if (inv_dout_err) begin
                     err_q     <= err_d;
                     wr_data_q <= {{DW{1'b0}}, lam_q, g_q, n_q};
                     wr_ok_q   <= 1'b0;
                  end else begin
                     wr_data_q <= {inv_dout_res, lam_q, g_q, n_q};
                     wr_ok_q   <= 1'b1;
                  end
               end
            end
            WRITE: begin
               wr_en_q <= 1'b0;
               idx_q   <= idx_d;
               if (idx_d < num_q) begin
                  state_q   <= FETCH;
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= rdb_q + idx_d;
               end else begin
                  state_q <= FINISH;
               end
            end
            FINISH: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_paillier_keygen_batch.sv
// Directed + randomized bench for paillier_keygen_batch with a
// latency-3 memory model and a brute-force key reference.
module tb_paillier_keygen_batch;
   import paillier_pkg::*;

   localparam int DW = 128;
   localparam int AW = 64;
   localparam int L = 3;
   localparam int BUDGET = 20000;

   logic            clk = 1'b0;
   logic            rst_n, start;
   logic [AW-1:0]   num_keys, rd_base, wr_base;
   logic            mem_rd_en, mem_wr_en, mem_wr_ok, busy, done;
   logic [AW-1:0]   mem_rd_addr, mem_wr_addr, err_count;
   logic [DW-1:0]   mem_rd_data;
   logic [4*DW-1:0] mem_wr_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   paillier_keygen_batch #(
      .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RD_LATENCY(L)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .num_keys(num_keys), .rd_base(rd_base), .wr_base(wr_base),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_ok(mem_wr_ok),
      .busy(busy), .done(done), .err_count(err_count)
   );

   // memory: data valid only in the L-th cycle after the strobe
   logic [DW-1:0] mem [logic [AW-1:0]];
   logic [DW-1:0] pd [L];
   logic          pv [L] = '{default: 1'b0};
   logic [DW-1:0] junk = '0;
   assign mem_rd_data = pv[L-1] ? pd[L-1] : junk;

   always @(posedge clk) begin
      junk  <= {$urandom, $urandom, $urandom, $urandom};
      pv[0] <= mem_rd_en;
      pd[0] <= mem.exists(mem_rd_addr) ? mem[mem_rd_addr] : junk;
      for (int i = 1; i < L; i++) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
   end

   logic [AW-1:0]   rq[$];
   logic [AW-1:0]   wq_a[$];
   logic [4*DW-1:0] wq_d[$];
   logic            wq_ok[$];

   always @(posedge clk) begin
      if (mem_rd_en) rq.push_back(mem_rd_addr);
      if (mem_wr_en) begin
         wq_a.push_back(mem_wr_addr);
         wq_d.push_back(mem_wr_data);
         wq_ok.push_back(mem_wr_ok);
      end
   end

   longint unsigned ep[$];
   longint unsigned eq[$];

   task automatic chk(input string tag, input logic [4*DW-1:0] obs,
                      input logic [4*DW-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // reference: key values straight from the definitions, mu by search
   task automatic model(input longint unsigned p, input longint unsigned q,
                        output logic [4*DW-1:0] rec, output logic ok);
      logic [DW-1:0] pw, qw, n, g, lam, mu;
      longint unsigned n64, l64;
      pw = DW'(p);
      qw = DW'(q);
      n = pw * qw;
      g = n + 1;
      lam = (pw - 1) * (qw - 1);
      mu = '0;
      ok = 1'b0;
      if (!(p < 3 || q < 3 || p == q || p % 2 == 0 || q % 2 == 0)) begin
         n64 = p * q;
         l64 = (p - 1) * (q - 1);
         for (longint unsigned x = 1; x < n64; x++) begin
            if ((l64 * x) % n64 == 1) begin
               mu = DW'(x);
               ok = 1'b1;
               break;
            end
         end
      end
      rec = {mu, lam, g, n};
   endtask

   task automatic load(input logic [AW-1:0] a, input longint unsigned p,
                       input longint unsigned q);
      mem[a] = {p, q};
      ep.push_back(p);
      eq.push_back(q);
   endtask

   task automatic clear_logs();
      rq.delete();
      wq_a.delete();
      wq_d.delete();
      wq_ok.delete();
   endtask

   function automatic longint unsigned rnd_val();
      if ($urandom_range(0, 4) == 0) return longint'($urandom_range(0, 20));
      return longint'($urandom_range(1, 127) * 2 + 1);
   endfunction

   // start at a negedge; returns edges from start to observed done
   task automatic run(input logic [AW-1:0] nk, input logic [AW-1:0] rb,
                      input logic [AW-1:0] wb, input bit rogue,
                      output int lat);
      num_keys = nk;
      rd_base = rb;
      wr_base = wb;
      start = 1'b1;
      lat = 0;
      for (int c = 1; c <= BUDGET; c++) begin
         @(negedge clk);
         if (c == 1) begin
            start = 1'b0;
            chk("busy_after_start", busy, 1);
         end
         if (rogue && c == 3) begin
            start = 1'b1;
            num_keys = 7;
            rd_base = rb + 100;
            wr_base = wb + 100;
         end
         if (rogue && c == 4) start = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
      end
      chk("done_seen", lat != 0, 1);
      @(negedge clk);
      chk("done_one_cycle", {busy, done}, 0);
   endtask

   task automatic check_batch(input int nk, input logic [AW-1:0] rb,
                              input logic [AW-1:0] wb);
      logic [4*DW-1:0] rec;
      logic ok;
      logic [AW-1:0] ea;
      int errs = 0;
      chk("read_count", rq.size(), nk);
      chk("write_count", wq_a.size(), nk);
      for (int i = 0; i < nk; i++) begin
         model(ep[i], eq[i], rec, ok);
         if (!ok) errs++;
         if (i < rq.size()) begin
            ea = rb + AW'(i);
            chk("rd_addr", rq[i], ea);
         end
         if (i < wq_a.size()) begin
            ea = wb + AW'(i);
            chk("wr_addr", wq_a[i], ea);
            chk("wr_data", wq_d[i], rec);
            chk("wr_ok", wq_ok[i], ok);
         end
      end
      chk("err_count", err_count, errs);
   endtask

   initial begin
      int lat;
      bit found;
      logic [AW-1:0] rb, wb;
      logic [4*DW-1:0] w;
      rst_n = 1'b1;
      start = 1'b0;
      num_keys = '0;
      rd_base = '0;
      wr_base = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_en", mem_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_wr_ok", mem_wr_ok, 0);
      chk("rst_err", err_count, 0);
      repeat (3) @(negedge clk);

      // single key, started on the first edge after reset release
      clear_logs(); ep.delete(); eq.delete();
      load(64'h100, 11, 13);
      rst_n = 1'b1;
      run(1, 64'h100, 64'h200, 0, lat);
      check_batch(1, 64'h100, 64'h200);
      w = (wq_d.size() > 0) ? wq_d[0] : '0;
      chk("t1_record", w, {128'd87, 128'd120, 128'd144, 128'd143});
      chk("t1_ok", (wq_ok.size() > 0) ? wq_ok[0] : 1'b0, 1);

      // empty batch
      clear_logs(); ep.delete(); eq.delete();
      run(0, 64'h5, 64'h6, 0, lat);
      chk("zero_latency", lat, 2);
      check_batch(0, 64'h5, 64'h6);

      // rejections
      clear_logs(); ep.delete(); eq.delete();
      load(64'h300, 11, 13);
      load(64'h301, 7, 7);
      load(64'h302, 4, 13);
      run(3, 64'h300, 64'h400, 0, lat);
      check_batch(3, 64'h300, 64'h400);
      chk("t3_err2", err_count, 2);
      repeat (3) @(negedge clk);
      chk("err_hold", err_count, 2);

      // address wrap, latency-3 capture
      clear_logs(); ep.delete(); eq.delete();
      rb = '1;
      load(rb, 11, 13);
      load(64'h0, 17, 19);
      run(2, rb, rb, 0, lat);
      check_batch(2, rb, rb);
      chk("wrap_rd1", (rq.size() > 1) ? rq[1] : 64'h1234, 0);

      // random batches
      for (int b = 0; b < 4; b++) begin
         clear_logs(); ep.delete(); eq.delete();
         rb = {$urandom, $urandom};
         wb = {$urandom, $urandom};
         for (int i = 0; i < 4; i++)
            load(rb + AW'(i), rnd_val(), rnd_val());
         run(4, rb, wb, 0, lat);
         check_batch(4, rb, wb);
      end

      // start while busy is ignored
      clear_logs(); ep.delete(); eq.delete();
      load(64'h700, 23, 29);
      load(64'h701, 31, 37);
      run(2, 64'h700, 64'h800, 1, lat);
      check_batch(2, 64'h700, 64'h800);

      // reset while the inverter is working
      clear_logs(); ep.delete(); eq.delete();
      load(64'h900, 251, 241);
      num_keys = 1;
      rd_base = 64'h900;
      wr_base = 64'hA00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (dut.state_q == INV_WAIT) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("reached_inv_wait", found, 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rd_en", mem_rd_en, 0);
      chk("mid_wr_en", mem_wr_en, 0);
      chk("mid_busy", busy, 0);
      chk("mid_done", done, 0);
      chk("mid_wr_data", mem_wr_data, 0);
      chk("mid_wr_ok", mem_wr_ok, 0);
      chk("mid_err", err_count, 0);
      clear_logs();
      repeat (4) @(negedge clk);
      chk("mid_no_access", rq.size() + wq_a.size(), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", rq.size() + wq_a.size() + busy, 0);
      run(1, 64'h900, 64'hA00, 0, lat);
      check_batch(1, 64'h900, 64'hA00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/paillier_keygen_batch.md
PAILLIER_KEYGEN_BATCH -- requirements
Module: paillier_keygen_batch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: key width (n, g, lambda, mu); p and q are DATA_WIDTH/2 bits.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 64: memory address and record-count width.
REQ-003 SHALL have parameter RD_LATENCY, default 1 (range 1..4): cycles from mem_rd_en to valid mem_rd_data.
REQ-004 SHALL have port clk, input, 1: single clock; all flops on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: single-cycle batch start pulse.
REQ-007 SHALL have port num_keys, input, ADDRESS_WIDTH: number of (p,q) records, sampled on start.
REQ-008 SHALL have port rd_base, input, ADDRESS_WIDTH: first read address, sampled on start.
REQ-009 SHALL have port wr_base, input, ADDRESS_WIDTH: first write address, sampled on start.
REQ-010 SHALL have port mem_rd_en, output, 1: read strobe.
REQ-011 SHALL have port mem_rd_addr, output, ADDRESS_WIDTH: read address.
REQ-012 SHALL have port mem_rd_data, input, DATA_WIDTH: record {p[DATA_WIDTH-1:DATA_WIDTH/2], q[DATA_WIDTH/2-1:0]}.
REQ-013 SHALL have port mem_wr_en, output, 1: write strobe.
REQ-014 SHALL have port mem_wr_addr, output, ADDRESS_WIDTH: write address.
REQ-015 SHALL have port mem_wr_data, output, 4*DATA_WIDTH: {mu, lambda, g, n}, n in the LSBs.
REQ-016 SHALL have port mem_wr_ok, output, 1: record valid flag written alongside the data.
REQ-017 SHALL have port busy, output, 1: high from the cycle after an accepted start until done.
REQ-018 SHALL have port done, output, 1: single-cycle batch completion pulse.
REQ-019 SHALL have port err_count, output, ADDRESS_WIDTH: number of rejected records in the current or last batch.

Function
REQ-020 SHALL accept start only in IDLE; start while busy SHALL be ignored.
REQ-021 SHALL use states IDLE, FETCH, WAIT_RD, COMPUTE, INV_REQ, INV_WAIT, WRITE and FINISH.
REQ-022 SHALL transition IDLE->FETCH on start with num_keys!=0, and IDLE->FINISH on start with num_keys==0, issuing no memory access in the latter case.
REQ-023 SHALL assert mem_rd_en for exactly one cycle in FETCH with mem_rd_addr=rd_base+index, then wait RD_LATENCY cycles in WAIT_RD and capture mem_rd_data.
REQ-024 SHALL compute, in COMPUTE, n=p*q, lambda=(p-1)*(q-1) and g=n+1, each truncated to DATA_WIDTH bits.
REQ-025 SHALL reject a record when p<3, q<3, p==q, p is even, or q is even; a rejected record SHALL bypass inversion and go to WRITE with mu=0 and mem_wr_ok=0.
REQ-026 SHALL hold inv_din_valid high in INV_REQ until inv_din_ready is seen, then go to INV_WAIT.
REQ-027 SHALL hold inv_dout_ready high in INV_WAIT; the dout handshake SHALL capture mu=lambda^-1 mod n.
REQ-028 SHALL treat inv_dout_err=1 (gcd(lambda,n)!=1) as a rejection: mu=0, mem_wr_ok=0.
REQ-029 SHALL increment err_count once per rejected record, saturating at all-ones.
REQ-030 SHALL assert mem_wr_en for exactly one cycle in WRITE with mem_wr_addr=wr_base+index.
REQ-031 SHALL increment index after WRITE, returning to FETCH if index<num_keys and going to FINISH otherwise.
REQ-032 SHALL let address arithmetic wrap modulo 2^ADDRESS_WIDTH.
REQ-033 SHALL pulse done for one cycle in FINISH and return to IDLE on the next cycle.
REQ-034 SHALL keep mem_wr_data stable from WRITE until the next WRITE.
REQ-035 SHALL keep err_count stable after done until the next accepted start, which SHALL clear it.

Reset
REQ-036 SHALL, on rst_n low, immediately force state=IDLE, index=0, err_count=0, mem_rd_en=0, mem_wr_en=0, done=0, busy=0, mem_wr_data=0 and mem_wr_ok=0.
REQ-037 SHALL abort a reset asserted mid-batch with no further memory access, and also reset the inverter instance.
REQ-038 SHALL accept start on the first clock edge after rst_n deasserts.

Structure
REQ-039 SHALL place the state enum and the record-field slice constants in package paillier_pkg.
REQ-040 SHALL instantiate one sub-module, mod_inverse, with ports clk, rst_n, din_valid/ready, din_base, din_mod, dout_valid/ready, dout_res and dout_err.
REQ-041 SHALL NOT use any combinational path from mem_rd_data to a memory output.

Verification
REQ-042 SHALL check: num_keys=1, p=11, q=13 -> one write with n=143, g=144, lambda=120, mu=87, mem_wr_ok=1, then done.
REQ-043 SHALL check: num_keys=0 -> done 2 cycles after start, with no mem_rd_en and no mem_wr_en.
REQ-044 SHALL check: 3 records {(11,13),(7,7),(4,13)} -> records 1 and 2 written with ok=0 and mu=0, err_count=2.
REQ-045 SHALL check: RD_LATENCY=3 with rd_base=all-ones and num_keys=2 -> read addresses all-ones then 0, data captured exactly 3 cycles after each mem_rd_en.
REQ-046 SHALL check: rst_n pulled low during INV_WAIT -> all outputs zero immediately, and a fresh batch then completes correctly.
REQ-047 SHALL check: start re-asserted while busy -> ignored, with the original batch results unchanged.
